// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, ALU/branch codes, register
// indices and the decoded-slot record carried between decode and the register file.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_BGE  = 4'h4,
        OP_BLTZ = 4'h5,
        OP_BEZ  = 4'h6,
        OP_BEQ  = 4'h7,
        OP_BNE  = 4'h8,
        OP_MOV  = 4'h9,
        OP_LDQ  = 4'hA,
        OP_LD   = 4'hB,
        OP_ST   = 4'hC
    } opcode_e;

    // ALU and branch codes line up with opcodes 0-8, so decode forwards op directly.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_GTE = 4'd4;
    localparam logic [3:0] ALU_LTZ = 4'd5;
    localparam logic [3:0] ALU_EZ  = 4'd6;
    localparam logic [3:0] ALU_EQ  = 4'd7;
    localparam logic [3:0] ALU_NE  = 4'd8;

    localparam logic [3:0] REG_ADR = 4'd4;

    typedef struct packed {
        logic       valid;
        logic [3:0] read_reg0;
        logic [3:0] read_reg1;
        logic [3:0] write_reg;
        logic       write;
        logic       immediate;
        logic       move;
        logic [1:0] quarter;
        logic       wr_full;
        logic [3:0] alu_op;
        logic [1:0] reg_to_mem;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode instruction handshake plus the branch flush line.
interface decode_stage_if;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;

    modport master (output instr_in, output instr_valid, output flush, input instr_ready);
    modport slave  (input instr_in, input instr_valid, input flush, output instr_ready);
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes; flags a read-after-write
// hazard when any pending destination matches a source the incoming instruction uses.
module hazard_scoreboard #(
    parameter int WB_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid_i,
    input  logic [3:0] issue_dest_i,
    input  logic       flush_i,
    input  logic [3:0] src0_i,
    input  logic       use0_i,
    input  logic [3:0] src1_i,
    input  logic       use1_i,
    input  logic [3:0] src2_i,
    input  logic       use2_i,
    output logic       hazard_o
);

    logic [WB_DEPTH-1:0] vld_q;
    logic [3:0]          dst_q [WB_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) dst_q[i] <= 4'd0;
        end else begin
            for (int i = WB_DEPTH - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                dst_q[i] <= dst_q[i-1];
            end
            vld_q[0] <= issue_valid_i && !flush_i;
            dst_q[0] <= issue_dest_i;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (vld_q[i] && ((use0_i && dst_q[i] == src0_i) ||
                             (use1_i && dst_q[i] == src1_i) ||
                             (use2_i && dst_q[i] == src2_i)))
                hazard_o = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: combinational decode of the fetched word into
// register-file controls, one output register slot, and RAW stall via the scoreboard.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_stage_if.slave        fetch_if,
    output logic                 out_valid,
    output logic [3:0]           readReg0,
    output logic [3:0]           readReg1,
    output logic [3:0]           writeReg,
    output logic                 write,
    output logic                 immediate,
    output logic                 move,
    output logic [1:0]           quarter,
    output logic                 wr_full,
    output logic [3:0]           ALU_operation,
    output logic [1:0]           regToMem,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 illegal
);

    logic [3:0] op, ra, rb, imm4;
    logic [1:0] q;
    decode_t    dec_d, dec_q;
    logic [3:0] src0, src1;
    logic       use0, use1;
    logic       hazard, accept;

    assign op   = fetch_if.instr_in[15:12];
    assign ra   = fetch_if.instr_in[11:8];
    assign rb   = fetch_if.instr_in[7:4];
    assign q    = fetch_if.instr_in[5:4];
    assign imm4 = fetch_if.instr_in[3:0];

    always_comb begin
        dec_d       = '0;
        dec_d.valid = 1'b1;
        src0        = 4'd0;
        src1        = 4'd0;
        use0        = 1'b0;
        use1        = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_d.alu_op    = op;
                dec_d.read_reg0 = ra;
                dec_d.read_reg1 = rb;
                dec_d.write_reg = ra;
                dec_d.write     = 1'b1;
                dec_d.wr_full   = 1'b1;
                src0 = ra; use0 = 1'b1;
                src1 = rb; use1 = 1'b1;
            end
            OP_BGE, OP_BEQ, OP_BNE: begin
                dec_d.alu_op    = op;
                dec_d.read_reg0 = ra;
                dec_d.read_reg1 = rb;
                src0 = ra; use0 = 1'b1;
                src1 = rb; use1 = 1'b1;
            end
            OP_BLTZ, OP_BEZ: begin
                dec_d.alu_op    = op;
                dec_d.read_reg0 = ra;
                dec_d.read_reg1 = rb;
                src0 = ra; use0 = 1'b1;
            end
            OP_MOV: begin
                dec_d.alu_op    = ALU_ADD;
                dec_d.move      = 1'b1;
                dec_d.read_reg0 = rb;
                dec_d.write_reg = ra;
                dec_d.write     = 1'b1;
                dec_d.wr_full   = 1'b1;
                src0 = rb; use0 = 1'b1;
            end
            OP_LDQ: begin
                // Nibble load writes ra but reads nothing, so it never stalls.
                dec_d.immediate = 1'b1;
                dec_d.read_reg0 = imm4;
                dec_d.quarter   = q;
                dec_d.write_reg = ra;
                dec_d.write     = 1'b1;
            end
            OP_LD: begin
                dec_d.mem_read  = 1'b1;
                dec_d.read_reg0 = REG_ADR;
                dec_d.write_reg = ra;
                dec_d.write     = 1'b1;
                dec_d.wr_full   = 1'b1;
                src0 = REG_ADR; use0 = 1'b1;
            end
            OP_ST: begin
                dec_d.mem_write  = 1'b1;
                dec_d.reg_to_mem = ra[1:0];
                dec_d.read_reg0  = REG_ADR;
                dec_d.read_reg1  = ra;
                src0 = ra;      use0 = 1'b1;
                src1 = REG_ADR; use1 = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    hazard_scoreboard #(.WB_DEPTH(WB_DEPTH)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (accept && dec_d.write),
        .issue_dest_i  (dec_d.write_reg),
        .flush_i       (fetch_if.flush),
        .src0_i        (src0),
        .use0_i        (use0),
        .src1_i        (src1),
        .use1_i        (use1),
        .src2_i        (4'd0),
        .use2_i        (1'b0),
        .hazard_o      (hazard)
    );

    assign fetch_if.instr_ready = !hazard;
    assign accept               = fetch_if.instr_valid && !hazard;

    // Flush drops an instruction accepted on the same edge; fetch still sees it consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            dec_q <= '0;
        else if (accept && !fetch_if.flush)    dec_q <= dec_d;
        else                                   dec_q <= '0;
    end

    assign out_valid     = dec_q.valid;
    assign readReg0      = dec_q.read_reg0;
    assign readReg1      = dec_q.read_reg1;
    assign writeReg      = dec_q.write_reg;
    assign write         = dec_q.write;
    assign immediate     = dec_q.immediate;
    assign move          = dec_q.move;
    assign quarter       = dec_q.quarter;
    assign wr_full       = dec_q.wr_full;
    assign ALU_operation = dec_q.alu_op;
    assign regToMem      = dec_q.reg_to_mem;
    assign mem_read      = dec_q.mem_read;
    assign mem_write     = dec_q.mem_write;
    assign illegal       = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: opcode vector table plus hazard, flush
// and reset sequences, with issued slots checked against a queue of expectations.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if fif ();

    logic       out_valid, write, immediate, move, wr_full, mem_read, mem_write, illegal;
    logic [3:0] readReg0, readReg1, writeReg, ALU_operation;
    logic [1:0] quarter, regToMem;

    decode_stage #(.WB_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_if      (fif),
        .out_valid     (out_valid),
        .readReg0      (readReg0),
        .readReg1      (readReg1),
        .writeReg      (writeReg),
        .write         (write),
        .immediate     (immediate),
        .move          (move),
        .quarter       (quarter),
        .wr_full       (wr_full),
        .ALU_operation (ALU_operation),
        .regToMem      (regToMem),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .illegal       (illegal)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] r0, r1, wr;
        logic       we, im, mv;
        logic [1:0] q;
        logic       wf;
        logic [3:0] alu;
        logic [1:0] rm;
        logic       mr, mw, il;
    } out_t;

    typedef struct {
        logic [15:0] instr;
        out_t        exp;
    } vec_t;

    out_t act;
    assign act = {out_valid, readReg0, readReg1, writeReg, write, immediate, move,
                  quarter, wr_full, ALU_operation, regToMem, mem_read, mem_write, illegal};

    int   checks = 0;
    int   failures = 0;
    vec_t exp_q[$];
    vec_t tv[16];

    function automatic out_t o(input int v, r0, r1, wr, we, im, mv, q, wf, alu, rm, mr, mw, il);
        out_t r;
        r.v = 1'(v); r.r0 = 4'(r0); r.r1 = 4'(r1); r.wr = 4'(wr);
        r.we = 1'(we); r.im = 1'(im); r.mv = 1'(mv); r.q = 2'(q); r.wf = 1'(wf);
        r.alu = 4'(alu); r.rm = 2'(rm); r.mr = 1'(mr); r.mw = 1'(mw); r.il = 1'(il);
        return r;
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    // Drive one instruction, hold it through any stall, and queue its expected slot.
    task automatic issue(input logic [15:0] ins, input out_t e, input logic fl, output int stalls);
        vec_t t;
        @(negedge clk);
        fif.instr_in    = ins;
        fif.instr_valid = 1'b1;
        fif.flush       = fl;
        stalls          = 0;
        #1;
        while (!fif.instr_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!fif.instr_ready) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout instr=%h", ins);
            fif.instr_valid = 1'b0;
            fif.flush       = 1'b0;
            return;
        end
        @(posedge clk);
        if (!fl) begin
            t.instr = ins;
            t.exp   = e;
            exp_q.push_back(t);
        end
        #1;
        fif.instr_valid = 1'b0;
        fif.flush       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_slot got=%h exp=none", act);
            end else begin
                vec_t t;
                t = exp_q.pop_front();
                chk($sformatf("slot_%h", t.instr), int'(act), int'(t.exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        fif.instr_in    = 16'h0000;
        fif.instr_valid = 1'b0;
        fif.flush       = 1'b0;

        tv[0]  = '{16'h0120, o(1,1,2,1,1,0,0,0,1,0,0,0,0,0)};
        tv[1]  = '{16'h1345, o(1,3,4,3,1,0,0,0,1,1,0,0,0,0)};
        tv[2]  = '{16'h2A7B, o(1,10,7,10,1,0,0,0,1,2,0,0,0,0)};
        tv[3]  = '{16'h3FE0, o(1,15,14,15,1,0,0,0,1,3,0,0,0,0)};
        tv[4]  = '{16'h4120, o(1,1,2,0,0,0,0,0,0,4,0,0,0,0)};
        tv[5]  = '{16'h5300, o(1,3,0,0,0,0,0,0,0,5,0,0,0,0)};
        tv[6]  = '{16'h6400, o(1,4,0,0,0,0,0,0,0,6,0,0,0,0)};
        tv[7]  = '{16'h7120, o(1,1,2,0,0,0,0,0,0,7,0,0,0,0)};
        tv[8]  = '{16'h8560, o(1,5,6,0,0,0,0,0,0,8,0,0,0,0)};
        tv[9]  = '{16'h9540, o(1,4,0,5,1,0,1,0,1,0,0,0,0,0)};
        tv[10] = '{16'hA25F, o(1,15,0,2,1,1,0,1,0,0,0,0,0,0)};
        tv[11] = '{16'hB300, o(1,4,0,3,1,0,0,0,1,0,0,1,0,0)};
        tv[12] = '{16'hC200, o(1,4,2,0,0,0,0,0,0,0,2,0,1,0)};
        tv[13] = '{16'hD123, o(1,0,0,0,0,0,0,0,0,0,0,0,0,1)};
        tv[14] = '{16'hE000, o(1,0,0,0,0,0,0,0,0,0,0,0,0,1)};
        tv[15] = '{16'hFFFF, o(1,0,0,0,0,0,0,0,0,0,0,0,0,1)};

        #12;
        chk("reset_outputs", int'(act), 0);
        chk("reset_ready", int'(fif.instr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outputs", int'(act), 0);
        chk("idle_ready", int'(fif.instr_ready), 1);

        // Each opcode in isolation, followed by a bubble check and a drain.
        for (int i = 0; i < 16; i++) begin
            issue(tv[i].instr, tv[i].exp, 1'b0, st);
            chk($sformatf("nostall_%h", tv[i].instr), st, 0);
            @(posedge clk);
            #1;
            chk($sformatf("bubble_after_%h", tv[i].instr), int'(act), 0);
            idle(1);
        end

        // RAW on r1: two full bubbles, then one when a gap already elapsed.
        issue(16'h0120, o(1,1,2,1,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'h0310, o(1,3,1,3,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        chk("raw_stall_2", st, 2);
        idle(2);
        issue(16'h0120, o(1,1,2,1,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        idle(1);
        issue(16'h0310, o(1,3,1,3,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        chk("raw_stall_1", st, 1);
        idle(2);

        // LDQ has no register source even when its destination is pending.
        issue(16'h0220, o(1,2,2,2,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'hA25F, o(1,15,0,2,1,1,0,1,0,0,0,0,0,0), 1'b0, st);
        chk("ldq_nostall", st, 0);
        idle(2);

        // MOV r5,r4 -> LD -> BEQ back to back; then LD behind a pending r4.
        issue(16'h9540, o(1,4,0,5,1,0,1,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'hB000, o(1,4,0,0,1,0,0,0,1,0,0,1,0,0), 1'b0, st);
        chk("ld_b2b", st, 0);
        issue(16'h7120, o(1,1,2,0,0,0,0,0,0,7,0,0,0,0), 1'b0, st);
        chk("beq_b2b", st, 0);
        idle(2);
        issue(16'h9420, o(1,2,0,4,1,0,1,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'hB100, o(1,4,0,1,1,0,0,0,1,0,0,1,0,0), 1'b0, st);
        chk("ld_adr_stall", st, 2);
        idle(2);

        // BLTZ ignores rb for hazard purposes.
        issue(16'h0520, o(1,5,2,5,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'h5150, o(1,1,5,0,0,0,0,0,0,5,0,0,0,0), 1'b0, st);
        chk("bltz_rb_free", st, 0);
        idle(2);

        // Flush on the accepting edge squashes the slot and its scoreboard entry.
        issue(16'h0120, o(1,1,2,1,1,0,0,0,1,0,0,0,0,0), 1'b1, st);
        chk("flush_accept", st, 0);
        @(negedge clk);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_write", int'(write), 0);
        issue(16'h0310, o(1,3,1,3,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        chk("flush_nostall", st, 0);
        idle(2);

        // Reset while a dependent instruction is stalled behind an illegal slot.
        issue(16'h0120, o(1,1,2,1,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        issue(16'hE000, o(1,0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0, st);
        chk("illegal_nostall", st, 0);
        @(negedge clk);
        fif.instr_in    = 16'h0310;
        fif.instr_valid = 1'b1;
        #1;
        chk("pre_rst_ready", int'(fif.instr_ready), 0);
        chk("pre_rst_illegal", int'(illegal), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_outputs", int'(act), 0);
        chk("rst_ready", int'(fif.instr_ready), 1);
        fif.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0310, o(1,3,1,3,1,0,0,0,1,0,0,0,0,0), 1'b0, st);
        chk("post_rst_nostall", st, 0);

        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
